exec_stage: RTL and testbench
=============================

# exec_stage

Execute stage of the pipelined core. It selects the ALU operands from register data, PC, immediate and forwarded values, then computes the ALU result with negative and zero flags. It packs the result, flags, control bits and register tags into one pipeline register (`bufferOut`) that feeds the memory stage.

## Interface
Parameters:
- `N`, default 4: datapath width (signed operands and result).
- `BW`, default 32: output buffer width; must equal 2·N+24. Elaboration error otherwise.

Ports:
- `clk`  in  1: the single clock; all state is on its rising edge.
- `rst`  in  1: reset, asynchronous and active-low; clears the buffer.
- `en`  in  1: buffer load enable.
- `rd1`, `rd2`  in  N signed: register-file operands.
- `pc`  in  N signed: PC of the instruction.
- `imm`  in  N signed: sign-extended immediate.
- `aluOut`  in  N signed: ALU result forwarded from the MEM stage.
- `result`  in  N signed: write-back value forwarded from the WB stage.
- `rd3`  in  N signed: store data, passed through.
- `aluControl`  in  4: ALU operation.
- `Ra`, `Rb`, `Rc`  in  4 each: register tags, passed through.
- `immSrc`  in  1: when 1, operand B is `imm`.
- `branchFlag`  in  1: when 1, operand A is `pc`; the bit is also passed through.
- `memWrite`, `memToReg`, `regWrite`  in  1 each: control bits, passed through.
- `opType`  in  2: instruction class, passed through.
- `opCode`  in  4: opcode, passed through.
- `Fa`, `Fb`  in  1 each: forwarding selects for A and B.
- `bufferOut`  out  BW: registered stage output.

## Operation
Operand selection (combinational):
- Forwarded A = `aluOut` if `Fa`, else `rd1`.
- Forwarded B = `result` if `Fb`, else `rd2`.
- srcA = `pc` if `branchFlag`, else forwarded A.
- srcB = `imm` if `immSrc`, else forwarded B.

ALU, `aluControl` encoding, N-bit two's-complement with wrap and no overflow detection:
- 0: SUB, A−B.
- 1: ADD, A+B.
- 2: AND.
- 3: OR.
- 4: CMP, A−B; the result is also latched.
- 5: XOR.
- 6: SHL, A << B[$clog2(N)-1:0].
- 7: SRA, arithmetic right shift, same shift amount as SHL.
- 8: MUL, low N bits of A·B.
- 9–15: PASS B.

Flags:
- negFlag = result[N-1].
- zeroFlag = (result == 0).

`bufferOut` packing, LSB first:
- [N-1:0] `rd3`
- [N+3:N] `Rc`
- [N+7:N+4] `Rb`
- [N+11:N+8] `Ra`
- [N+12] `regWrite`
- [N+13] `memToReg`
- [N+14] `memWrite`
- [N+15] `branchFlag`
- [N+16] negFlag
- [N+17] zeroFlag
- [2N+17:N+18] ALU result
- [2N+21:2N+18] `opCode`
- [2N+23:2N+22] `opType`

## Timing
- Single pipeline register; latency 1 cycle from inputs to `bufferOut`.
- On a rising edge with `en`=1, the register loads the packed word. With `en`=0 it holds (stall).
- `rst` low clears `bufferOut` to 0 immediately, regardless of clock and `en`. It stays 0 until the first rising edge after `rst` goes high.
- If reset is asserted mid-operation, the in-flight word is discarded.
- Operand muxes, ALU and flags are fully combinational within the cycle.
- No handshake beyond `en`.

## Configuration
- `EXEC_STAGE_FWD_EN` defined: `Fa`/`Fb` forwarding muxes are present as described above.
- Not defined: forwarded A = `rd1` and forwarded B = `rd2` unconditionally. `Fa`, `Fb`, `aluOut` and `result` are ignored. The ports remain present.

## Structure
- Package `exec_pkg` holds:
  - `alu_op_e` enum for the `aluControl` encodings;
  - localparam bit offsets of every `bufferOut` field, as functions of N;
  - the `BW == 2*N+24` rule.
- One sub-module, `alu`: parameter N; inputs A, B and op; outputs result, neg, zero.
- The top holds the muxes, packing and register.

## Test plan
N=4, BW=32, forwarding off unless stated.
- Reset: `rst` low with random inputs -> `bufferOut` = 0 immediately. After release and one edge, it loads the packed word.
- ADD: rd1=2, rd2=2, immSrc=0, branchFlag=0, aluControl=1, Ra=1, Rb=2, Rc=3, rd3=0, opCode=1, opType=0. After one edge, check:
  - [25:22]=4, [3:0]=0, [7:4]=3, [11:8]=2, [15:12]=1;
  - bits 16–21 = 0;
  - [29:26]=1, [31:30]=0.
- CMP with immediate: rd1=2, imm=2, immSrc=1, aluControl=4 -> [25:22]=0, zeroFlag [21]=1, negFlag [20]=0.
- Branch SUB: pc=1, rd2=2, branchFlag=1, immSrc=0, aluControl=0 -> signed [25:22]=−1 (4'hF), negFlag=1, [19]=1.
- Forwarding with `EXEC_STAGE_FWD_EN` defined: rd1=0, aluOut=5, Fa=1, rd2=0, result=2, Fb=1, ADD -> result 7. With the macro undefined, the same stimulus gives 0 and zeroFlag=1.
- Stall: latch a word, set `en`=0, change all inputs for 3 cycles -> `bufferOut` unchanged.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, bufferOut field
// offsets (as functions of the datapath width) and the buffer width rule.
package exec_pkg;

  typedef enum logic [3:0] {
    ALU_SUB  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_CMP  = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SHL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_MUL  = 4'd8
  } alu_op_e;

  localparam int TAG_W    = 4;
  localparam int OPCODE_W = 4;
  localparam int OPTYPE_W = 2;

  function automatic int off_rd3(input int n);        return 0;        endfunction
  function automatic int off_rc(input int n);         return n;        endfunction
  function automatic int off_rb(input int n);         return n + 4;    endfunction
  function automatic int off_ra(input int n);         return n + 8;    endfunction
  function automatic int off_reg_write(input int n);  return n + 12;   endfunction
  function automatic int off_mem_to_reg(input int n); return n + 13;   endfunction
  function automatic int off_mem_write(input int n);  return n + 14;   endfunction
  function automatic int off_branch(input int n);     return n + 15;   endfunction
  function automatic int off_neg(input int n);        return n + 16;   endfunction
  function automatic int off_zero(input int n);       return n + 17;   endfunction
  function automatic int off_res(input int n);        return n + 18;   endfunction
  function automatic int off_opcode(input int n);     return 2*n + 18; endfunction
  function automatic int off_optype(input int n);     return 2*n + 22; endfunction

  function automatic bit bw_valid(input int n, input int bw);
    return bw == 2*n + 24;
  endfunction

endpackage

// File: rtl/exec_stage_alu.sv
// N-bit two's-complement ALU with negative and zero flags; wraps silently.
module alu
  import exec_pkg::*;
#(
  parameter int N = 4
) (
  input  logic signed [N-1:0] A,
  input  logic signed [N-1:0] B,
  input  logic        [3:0]   op,
  output logic signed [N-1:0] result,
  output logic                neg,
  output logic                zero
);

  // Shift amount uses only the low log2(N) bits of B.
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [SW-1:0] shamt;
  assign shamt = B[SW-1:0];

  always_comb begin
    result = B;
    case (op)
      ALU_SUB: result = A - B;
      ALU_ADD: result = A + B;
      ALU_AND: result = A & B;
      ALU_OR:  result = A | B;
      ALU_CMP: result = A - B;
      ALU_XOR: result = A ^ B;
      ALU_SHL: result = A << shamt;
      ALU_SRA: result = A >>> shamt;
      ALU_MUL: result = A * B;
      default: result = B;
    endcase
  end

  assign neg  = result[N-1];
  assign zero = (result == '0);

endmodule

// File: rtl/exec_stage.sv
// Execute stage: operand muxes, ALU and the EX/MEM pipeline register.
// Define EXEC_STAGE_FWD_EN to enable the Fa/Fb forwarding muxes.
module exec_stage
  import exec_pkg::*;
#(
  parameter int N  = 4,
  parameter int BW = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic signed [N-1:0] rd1,
  input  logic signed [N-1:0] rd2,
  input  logic signed [N-1:0] pc,
  input  logic signed [N-1:0] imm,
  input  logic signed [N-1:0] aluOut,
  input  logic signed [N-1:0] result,
  input  logic signed [N-1:0] rd3,
  input  logic        [3:0]   aluControl,
  input  logic        [3:0]   Ra,
  input  logic        [3:0]   Rb,
  input  logic        [3:0]   Rc,
  input  logic                immSrc,
  input  logic                branchFlag,
  input  logic                memWrite,
  input  logic                memToReg,
  input  logic                regWrite,
  input  logic        [1:0]   opType,
  input  logic        [3:0]   opCode,
  input  logic                Fa,
  input  logic                Fb,
  output logic        [BW-1:0] bufferOut
);

  if (!bw_valid(N, BW)) begin : g_bw_check
    $error("exec_stage: BW must equal 2*N+24");
  end

  localparam int RD3_LO = off_rd3(N);
  localparam int RC_LO  = off_rc(N);
  localparam int RB_LO  = off_rb(N);
  localparam int RA_LO  = off_ra(N);
  localparam int RW_B   = off_reg_write(N);
  localparam int M2R_B  = off_mem_to_reg(N);
  localparam int MW_B   = off_mem_write(N);
  localparam int BR_B   = off_branch(N);
  localparam int NEG_B  = off_neg(N);
  localparam int ZERO_B = off_zero(N);
  localparam int RES_LO = off_res(N);
  localparam int OPC_LO = off_opcode(N);
  localparam int OPT_LO = off_optype(N);

  logic signed [N-1:0] fwd_a, fwd_b, src_a, src_b, alu_res;
  logic                alu_neg, alu_zero;
  logic [BW-1:0]       packed_word;

`ifdef EXEC_STAGE_FWD_EN
  assign fwd_a = Fa ? aluOut : rd1;
  assign fwd_b = Fb ? result : rd2;
`else
  // Forwarding ports stay on the interface but are deliberately ignored.
  logic unused_fwd;
  assign unused_fwd = ^{Fa, Fb, aluOut, result};
  assign fwd_a = rd1;
  assign fwd_b = rd2;
`endif

  assign src_a = branchFlag ? pc  : fwd_a;
  assign src_b = immSrc     ? imm : fwd_b;

  alu #(.N(N)) u_alu (
    .A      (src_a),
    .B      (src_b),
    .op     (aluControl),
    .result (alu_res),
    .neg    (alu_neg),
    .zero   (alu_zero)
  );

  always_comb begin
    packed_word = '0;
    packed_word[RD3_LO +: N]        = rd3;
    packed_word[RC_LO  +: TAG_W]    = Rc;
    packed_word[RB_LO  +: TAG_W]    = Rb;
    packed_word[RA_LO  +: TAG_W]    = Ra;
    packed_word[RW_B]               = regWrite;
    packed_word[M2R_B]              = memToReg;
    packed_word[MW_B]               = memWrite;
    packed_word[BR_B]               = branchFlag;
    packed_word[NEG_B]              = alu_neg;
    packed_word[ZERO_B]             = alu_zero;
    packed_word[RES_LO +: N]        = alu_res;
    packed_word[OPC_LO +: OPCODE_W] = opCode;
    packed_word[OPT_LO +: OPTYPE_W] = opType;
  end

  // Reset discards any in-flight word; en=0 stalls the stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bufferOut <= '0;
    end else if (en) begin
      bufferOut <= packed_word;
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Directed, table-driven bench for exec_stage (N=4, BW=32).
module tb_exec_stage;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic signed [3:0] rd1, rd2, pc, imm, aluOut, result, rd3;
  logic        [3:0] aluControl, Ra, Rb, Rc, opCode;
  logic              immSrc, branchFlag, memWrite, memToReg, regWrite, Fa, Fb;
  logic        [1:0] opType;
  logic       [31:0] bufferOut;

  int checks = 0;
  int failures = 0;

  exec_stage #(.N(4), .BW(32)) dut (
    .clk(clk), .rst(rst), .en(en),
    .rd1(rd1), .rd2(rd2), .pc(pc), .imm(imm), .aluOut(aluOut), .result(result),
    .rd3(rd3), .aluControl(aluControl), .Ra(Ra), .Rb(Rb), .Rc(Rc),
    .immSrc(immSrc), .branchFlag(branchFlag), .memWrite(memWrite),
    .memToReg(memToReg), .regWrite(regWrite), .opType(opType), .opCode(opCode),
    .Fa(Fa), .Fb(Fb), .bufferOut(bufferOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  aluc, rd1, rd2, pc, imm;
    logic        immSrc, br;
    logic [3:0]  Ra, Rb, Rc, rd3;
    logic        rw, m2r, mw;
    logic [1:0]  opType;
    logic [3:0]  opCode;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mkVec(
    input logic [3:0] aluc, v_rd1, v_rd2, v_pc, v_imm,
    input logic v_immSrc, v_br,
    input logic [3:0] v_Ra, v_Rb, v_Rc, v_rd3,
    input logic v_rw, v_m2r, v_mw,
    input logic [1:0] v_opType,
    input logic [3:0] v_opCode,
    input logic [31:0] v_exp);
    vec_t v;
    v.aluc = aluc; v.rd1 = v_rd1; v.rd2 = v_rd2; v.pc = v_pc; v.imm = v_imm;
    v.immSrc = v_immSrc; v.br = v_br;
    v.Ra = v_Ra; v.Rb = v_Rb; v.Rc = v_Rc; v.rd3 = v_rd3;
    v.rw = v_rw; v.m2r = v_m2r; v.mw = v_mw;
    v.opType = v_opType; v.opCode = v_opCode; v.exp = v_exp;
    return v;
  endfunction

  // Drives one vector's inputs; forwarding sources are noise with Fa/Fb off.
  task automatic applyStimulus(input vec_t v);
    aluControl = v.aluc; rd1 = v.rd1; rd2 = v.rd2; pc = v.pc; imm = v.imm;
    immSrc = v.immSrc; branchFlag = v.br;
    Ra = v.Ra; Rb = v.Rb; Rc = v.Rc; rd3 = v.rd3;
    regWrite = v.rw; memToReg = v.m2r; memWrite = v.mw;
    opType = v.opType; opCode = v.opCode;
    aluOut = 4'($urandom); result = 4'($urandom);
    Fa = 1'b0; Fb = 1'b0;
  endtask

  task automatic randomInputs();
    {rd1, rd2, pc, imm, aluOut, result, rd3} = 28'($urandom);
    {aluControl, Ra, Rb, Rc, opCode} = 20'($urandom);
    {immSrc, branchFlag, memWrite, memToReg, regWrite, Fa, Fb, opType} = 9'($urandom);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] exp);
    checks++;
    if (bufferOut !== exp) begin
      failures++;
      $display("[TB] FAIL %s: bufferOut=%08h expected=%08h", name, bufferOut, exp);
    end
  endtask

  initial begin
    // aluc rd1 rd2 pc imm iS br Ra Rb Rc rd3 rw m2r mw opT opC expected
    vecs[0]  = mkVec(4'h1, 4'h2, 4'h2, 4'h6, 4'h5, 0, 0, 4'h1, 4'h2, 4'h3, 4'h0, 0, 0, 0, 2'd0, 4'h1, 32'h0500_1230);
    vecs[1]  = mkVec(4'h4, 4'h2, 4'h0, 4'h0, 4'h2, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 2'd1, 4'h4, 32'h5020_0000);
    vecs[2]  = mkVec(4'h0, 4'h7, 4'h2, 4'h1, 4'h3, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 2'd2, 4'h0, 32'h83D9_0000);
    vecs[3]  = mkVec(4'h2, 4'hC, 4'hA, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h5, 0, 0, 1, 2'd0, 4'h2, 32'h0A14_0005);
    vecs[4]  = mkVec(4'h3, 4'h4, 4'h1, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 4'hF, 4'h0, 0, 1, 0, 2'd0, 4'h0, 32'h0142_00F0);
    vecs[5]  = mkVec(4'h5, 4'hF, 4'hF, 4'h0, 4'h0, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0, 0, 0, 0, 2'd0, 4'h0, 32'h0020_F000);
    vecs[6]  = mkVec(4'h6, 4'h3, 4'h6, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 2'd0, 4'h0, 32'h0310_0000);
    vecs[7]  = mkVec(4'h7, 4'h8, 4'h3, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 2'd3, 4'h0, 32'hC3D0_0000);
    vecs[8]  = mkVec(4'h8, 4'h3, 4'h2, 4'h0, 4'h7, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 2'd0, 4'h0, 32'h0140_0000);
    vecs[9]  = mkVec(4'hC, 4'h1, 4'h9, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 2'd0, 4'hF, 32'h3E50_0000);
    vecs[10] = mkVec(4'h1, 4'h7, 4'h1, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 2'd0, 4'h0, 32'h0210_0000);
    vecs[11] = mkVec(4'h0, 4'h8, 4'h1, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 2'd0, 4'h0, 32'h01C0_0000);

    rst = 1'b0;
    en  = 1'b1;
    randomInputs();
    #1;
    checkOutput("reset_async", 32'h0);
    @(posedge clk); #1;
    checkOutput("reset_held_edge", 32'h0);

    @(negedge clk);
    rst = 1'b1;
    applyStimulus(vecs[0]);
    @(posedge clk); #1;
    checkOutput("reset_release_load", vecs[0].exp);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Stall: word from vec0 must survive three cycles of changing inputs.
    @(negedge clk);
    applyStimulus(vecs[0]);
    @(posedge clk); #1;
    checkOutput("stall_load", vecs[0].exp);
    @(negedge clk);
    en = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(vecs[i + 2]);
      @(posedge clk); #1;
      checkOutput($sformatf("stall_hold%0d", i), vecs[0].exp);
      @(negedge clk);
    end
    en = 1'b1;

    // Mid-operation reset discards the pending word, then reload resumes.
    applyStimulus(vecs[1]);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("reset_midop", 32'h0);
    @(posedge clk); #1;
    checkOutput("reset_midop_edge", 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset_midop_reload", vecs[1].exp);

    // Forwarding: ADD of rd1=0/rd2=0 with aluOut=5, result=2 selected.
    @(negedge clk);
    applyStimulus(vecs[10]);
    rd1 = 4'h0; rd2 = 4'h0; aluOut = 4'h5; result = 4'h2; Fa = 1'b1; Fb = 1'b1;
    @(posedge clk); #1;
`ifdef EXEC_STAGE_FWD_EN
    checkOutput("forwarding", 32'h01C0_0000);
`else
    checkOutput("forwarding_off", 32'h0020_0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
